// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants and state encoding for the IF/MEM memory bus arbiter.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DBUS  = 2'd1,
        IBUS  = 2'd2,
        DRAIN = 2'd3
    } arb_state_e;

    localparam logic CHIP_ENABLE   = 1'b1;
    localparam logic CHIP_DISABLE  = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic RST_ENABLE    = 1'b1;

    // Replicated to the byte-select width at the point of use.
    localparam logic ALL_BYTES = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Single-ported memory bus: master is the arbiter, slave is the memory.
interface mem_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned SEL_W = DATA_W / 8;

    logic              mem_ce_o;
    logic              mem_we_o;
    logic [SEL_W-1:0]  mem_sel_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic [DATA_W-1:0] mem_data_i;
    logic              mem_ack_i;

    modport master (
        output mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o, mem_data_o,
        input  mem_data_i, mem_ack_i
    );

    modport slave (
        input  mem_ce_o, mem_we_o, mem_sel_o, mem_addr_o, mem_data_o,
        output mem_data_i, mem_ack_i
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Serialises instruction-fetch and data accesses onto one memory bus; the
// data side wins ties, and a flushed in-flight cycle is drained and discarded.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  if_ce_i,
    input  logic [ADDR_W-1:0]     if_addr_i,
    output logic [DATA_W-1:0]     if_data_o,
    output logic                  if_stallreq_o,
    input  logic                  d_ce_i,
    input  logic                  d_we_i,
    input  logic [DATA_W/8-1:0]   d_sel_i,
    input  logic [ADDR_W-1:0]     d_addr_i,
    input  logic [DATA_W-1:0]     d_wdata_i,
    output logic [DATA_W-1:0]     d_rdata_o,
    output logic                  d_stallreq_o,
    mem_bus_arbiter_if.master     bus
);
    localparam int unsigned SEL_W = DATA_W / 8;

    arb_state_e        state_q;
    logic              ce_q;
    logic              we_q;
    logic [SEL_W-1:0]  sel_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_data_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              i_done_q;
    logic              d_done_q;

    logic d_pend_c;
    logic i_pend_c;

    // A side that just completed is masked for one cycle so it is not re-issued.
    assign d_pend_c = d_ce_i & ~d_done_q;
    assign i_pend_c = if_ce_i & ~i_done_q;

    assign if_stallreq_o = if_ce_i & ~i_done_q & ~flush_i;
    assign d_stallreq_o  = d_ce_i  & ~d_done_q & ~flush_i;

    // Arbitration FSM with bus-holding register bank.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q   <= IDLE;
            ce_q      <= CHIP_DISABLE;
            we_q      <= WRITE_DISABLE;
            sel_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            if_data_q <= '0;
            d_rdata_q <= '0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
        end else begin
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!flush_i) begin
                        if (d_pend_c) begin
                            state_q <= DBUS;
                            ce_q    <= CHIP_ENABLE;
                            we_q    <= d_we_i;
                            sel_q   <= d_sel_i;
                            addr_q  <= d_addr_i;
                            wdata_q <= d_wdata_i;
                        end else if (i_pend_c) begin
                            state_q <= IBUS;
                            ce_q    <= CHIP_ENABLE;
                            we_q    <= WRITE_DISABLE;
                            sel_q   <= {SEL_W{ALL_BYTES}};
                            addr_q  <= if_addr_i;
                        end
                    end
                end
                DBUS, IBUS: begin
                    if (bus.mem_ack_i) begin
                        state_q <= IDLE;
                        ce_q    <= CHIP_DISABLE;
                        // A flush coinciding with ack still completes, but silently.
                        if (state_q == DBUS) begin
                            d_rdata_q <= bus.mem_data_i;
                            d_done_q  <= ~flush_i;
                        end else begin
                            if_data_q <= bus.mem_data_i;
                            i_done_q  <= ~flush_i;
                        end
                    end else if (flush_i) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.mem_ack_i) begin
                        state_q <= IDLE;
                        ce_q    <= CHIP_DISABLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ce_q    <= CHIP_DISABLE;
                end
            endcase
        end
    end

    assign bus.mem_ce_o   = ce_q;
    assign bus.mem_we_o   = we_q;
    assign bus.mem_sel_o  = sel_q;
    assign bus.mem_addr_o = addr_q;
    assign bus.mem_data_o = wdata_q;
    assign if_data_o      = if_data_q;
    assign d_rdata_o      = d_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table, random episodes
// against a transaction-level model, and directed multi-cycle sequences.
module tb_mem_bus_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        if_ce_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_stallreq_o;
    logic        d_ce_i;
    logic        d_we_i;
    logic [3:0]  d_sel_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [31:0] d_rdata_o;
    logic        d_stallreq_o;

    mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .if_ce_i       (if_ce_i),
        .if_addr_i     (if_addr_i),
        .if_data_o     (if_data_o),
        .if_stallreq_o (if_stallreq_o),
        .d_ce_i        (d_ce_i),
        .d_we_i        (d_we_i),
        .d_sel_i       (d_sel_i),
        .d_addr_i      (d_addr_i),
        .d_wdata_i     (d_wdata_i),
        .d_rdata_o     (d_rdata_o),
        .d_stallreq_o  (d_stallreq_o),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          dce;
        bit          dwe;
        logic [3:0]  sel;
        logic [31:0] daddr;
        logic [31:0] wdata;
        bit          ice;
        logic [31:0] iaddr;
        int          waits;
        int          exp_d;
        int          exp_i;
        int          exp_n;
    } vec_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        we;
        logic [3:0]  sel;
    } txn_t;

    int          checks = 0;
    int          errors = 0;
    int          resp_waits;
    int          ce_cnt;
    bit          resp_en;
    bit          ovr_en;
    logic [31:0] ovr_data;
    logic        prev_ce;
    int          stable_err;
    int          ep_d_stall;
    int          ep_i_stall;
    txn_t        txq[$];
    logic [31:0] m_if_data;
    vec_t        tbl[6];

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: ack after resp_waits wait cycles of mem_ce_o.
    task automatic respond();
        if (!resp_en) return;
        if (bus.mem_ce_o) begin
            bus.mem_ack_i  = (ce_cnt == resp_waits);
            bus.mem_data_i = ovr_en ? ovr_data : mem_fn(bus.mem_addr_o);
            ce_cnt++;
        end else begin
            ce_cnt         = 0;
            bus.mem_ack_i  = 1'b0;
            bus.mem_data_i = 32'h0;
        end
    endtask

    task automatic track_bus();
        txn_t t;
        t.addr = bus.mem_addr_o;
        t.data = bus.mem_data_o;
        t.we   = bus.mem_we_o;
        t.sel  = bus.mem_sel_o;
        if (bus.mem_ce_o && !prev_ce) txq.push_back(t);
        else if (bus.mem_ce_o && txq.size() > 0 && txq[txq.size()-1] !== t) stable_err++;
        prev_ce = bus.mem_ce_o;
    endtask

    // Apply one request episode; each side drops ce once its stall request falls.
    task automatic run_ep(input vec_t v);
        int n;
        bit d_act;
        bit i_act;
        resp_waits = v.waits;
        ce_cnt     = 0;
        txq.delete();
        stable_err = 0;
        ep_d_stall = -1;
        ep_i_stall = -1;
        d_ce_i = v.dce;  d_we_i = v.dwe;  d_sel_i = v.sel;
        d_addr_i = v.daddr;  d_wdata_i = v.wdata;
        if_ce_i = v.ice;  if_addr_i = v.iaddr;
        d_act = v.dce;  i_act = v.ice;  n = 0;
        while ((d_act || i_act) && n < 60) begin
            respond();
            #1;
            track_bus();
            if (d_act && !d_stallreq_o) begin ep_d_stall = n; d_act = 1'b0; d_ce_i = 1'b0; end
            if (i_act && !if_stallreq_o) begin ep_i_stall = n; i_act = 1'b0; if_ce_i = 1'b0; end
            tick();
            n++;
        end
        d_ce_i = 1'b0;
        if_ce_i = 1'b0;
        for (int t = 0; t < 4; t++) begin
            respond();
            #1;
            track_bus();
            tick();
        end
    endtask

    task automatic ep_check(input vec_t v, input string tag);
        int idx;
        idx = 0;
        chk({tag, ".ntxn"}, 64'(txq.size()), 64'(v.exp_n));
        chk({tag, ".stable"}, 64'(stable_err), 64'd0);
        if (v.dce) begin
            chk({tag, ".dstall"}, 64'(ep_d_stall), 64'(v.exp_d));
            if (txq.size() > 0) begin
                chk({tag, ".daddr"}, 64'(txq[0].addr), 64'(v.daddr));
                chk({tag, ".dwe"},   64'(txq[0].we),   64'(v.dwe));
                chk({tag, ".dsel"},  64'(txq[0].sel),  64'(v.sel));
                if (v.dwe) chk({tag, ".wdata"}, 64'(txq[0].data), 64'(v.wdata));
            end
            if (!v.dwe) chk({tag, ".rdata"}, 64'(d_rdata_o), 64'(mem_fn(v.daddr)));
            idx = 1;
        end
        if (v.ice) begin
            chk({tag, ".istall"}, 64'(ep_i_stall), 64'(v.exp_i));
            if (txq.size() > idx) begin
                chk({tag, ".iaddr"}, 64'(txq[idx].addr), 64'(v.iaddr));
                chk({tag, ".iwe"},   64'(txq[idx].we),   64'd0);
                chk({tag, ".isel"},  64'(txq[idx].sel),  64'hF);
            end
            m_if_data = mem_fn(v.iaddr);
        end
        chk({tag, ".ifdata"}, 64'(if_data_o), 64'(m_if_data));
    endtask

    // Reference timing: a lone request stalls 2+w; a fetch queued behind data
    // waits for the whole data transaction plus its own.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        r = v;
        r.exp_n = int'(v.dce) + int'(v.ice);
        r.exp_d = 2 + v.waits;
        r.exp_i = v.dce ? 2 * (2 + v.waits) : 2 + v.waits;
        return r;
    endfunction

    initial begin
        int   rises;
        int   sides;
        vec_t v;

        rst = 1'b1;  flush_i = 1'b0;  if_ce_i = 1'b0;  if_addr_i = 32'h0;
        d_ce_i = 1'b0;  d_we_i = 1'b0;  d_sel_i = 4'h0;  d_addr_i = 32'h0;  d_wdata_i = 32'h0;
        bus.mem_ack_i = 1'b0;  bus.mem_data_i = 32'h0;
        resp_en = 1'b1;  ovr_en = 1'b0;  ovr_data = 32'h0;  resp_waits = 0;  ce_cnt = 0;
        prev_ce = 1'b0;  m_if_data = 32'h0;

        repeat (3) tick();
        chk("rst.ce",     64'(bus.mem_ce_o),   64'd0);
        chk("rst.we",     64'(bus.mem_we_o),   64'd0);
        chk("rst.addr",   64'(bus.mem_addr_o), 64'd0);
        chk("rst.ifdata", 64'(if_data_o),      64'd0);
        chk("rst.drdata", 64'(d_rdata_o),      64'd0);
        rst = 1'b0;
        tick();

        // Flush masks the stall and blocks any grant in that cycle.
        d_ce_i = 1'b1;  d_addr_i = 32'h44;  flush_i = 1'b1;
        #1;
        chk("flush.dstall", 64'(d_stallreq_o), 64'd0);
        tick();
        chk("flush.nogrant", 64'(bus.mem_ce_o), 64'd0);
        d_ce_i = 1'b0;  flush_i = 1'b0;
        tick();

        tbl[0] = '{dce:1'b1, dwe:1'b0, sel:4'hF, daddr:32'h1000, wdata:32'h0,
                   ice:1'b0, iaddr:32'h0,    waits:0, exp_d:2, exp_i:-1, exp_n:1};
        tbl[1] = '{dce:1'b0, dwe:1'b0, sel:4'h0, daddr:32'h0,    wdata:32'h0,
                   ice:1'b1, iaddr:32'h2004, waits:1, exp_d:-1, exp_i:3, exp_n:1};
        tbl[2] = '{dce:1'b1, dwe:1'b0, sel:4'hF, daddr:32'h3008, wdata:32'h0,
                   ice:1'b1, iaddr:32'h400C, waits:2, exp_d:4, exp_i:8, exp_n:2};
        tbl[3] = '{dce:1'b1, dwe:1'b1, sel:4'h3, daddr:32'h500,  wdata:32'hCAFEF00D,
                   ice:1'b1, iaddr:32'h600,  waits:0, exp_d:2, exp_i:4, exp_n:2};
        tbl[4] = '{dce:1'b1, dwe:1'b1, sel:4'h3, daddr:32'h200,  wdata:32'h1234ABCD,
                   ice:1'b0, iaddr:32'h0,    waits:3, exp_d:5, exp_i:-1, exp_n:1};
        tbl[5] = '{dce:1'b1, dwe:1'b0, sel:4'hF, daddr:32'h700,  wdata:32'h0,
                   ice:1'b1, iaddr:32'h800,  waits:1, exp_d:3, exp_i:6, exp_n:2};
        for (int i = 0; i < 6; i++) begin
            run_ep(tbl[i]);
            ep_check(tbl[i], $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 30; i++) begin
            sides   = int'($urandom_range(1, 3));
            v.dce   = sides[0];
            v.ice   = sides[1];
            v.dwe   = 1'($urandom_range(0, 1));
            v.sel   = 4'($urandom_range(1, 15));
            v.daddr = $urandom & 32'hFFFF_FFFC;
            v.wdata = $urandom;
            v.iaddr = $urandom & 32'hFFFF_FFFC;
            v.waits = int'($urandom_range(0, 3));
            v = model(v);
            run_ep(v);
            ep_check(v, $sformatf("rnd%0d", i));
        end

        // Zero-wait load returning a fixed word.
        ovr_en = 1'b1;  ovr_data = 32'hDEADBEEF;  resp_waits = 0;
        d_ce_i = 1'b1;  d_we_i = 1'b0;  d_sel_i = 4'hF;  d_addr_i = 32'h100;
        respond();  #1;  chk("load.c0.stall", 64'(d_stallreq_o), 64'd1);  tick();
        respond();  #1;  chk("load.c1.ce", 64'(bus.mem_ce_o), 64'd1);
        chk("load.c1.stall", 64'(d_stallreq_o), 64'd1);  tick();
        respond();  #1;  chk("load.c2.rdata", 64'(d_rdata_o), 64'hDEADBEEF);
        chk("load.c2.stall", 64'(d_stallreq_o), 64'd0);
        d_ce_i = 1'b0;  ovr_en = 1'b0;  tick();
        repeat (2) begin respond(); tick(); end

        // Flush during the first fetch cycle: drained, result discarded.
        ovr_en = 1'b1;  ovr_data = 32'h0;  resp_waits = 2;
        if_ce_i = 1'b1;  if_addr_i = 32'h40;
        respond();  #1;  tick();
        flush_i = 1'b1;  respond();  #1;  chk("fl.c1.ce", 64'(bus.mem_ce_o), 64'd1);  tick();
        flush_i = 1'b0;  respond();  #1;  chk("fl.c2.ce", 64'(bus.mem_ce_o), 64'd1);  tick();
        respond();  #1;  chk("fl.c3.ce", 64'(bus.mem_ce_o), 64'd1);  tick();
        if_addr_i = 32'h20;  respond();  #1;
        chk("fl.c4.ce", 64'(bus.mem_ce_o), 64'd0);
        chk("fl.c4.ifdata", 64'(if_data_o), 64'(m_if_data));
        chk("fl.c4.nodone", 64'(if_stallreq_o), 64'd1);  tick();
        ovr_en = 1'b0;  resp_waits = 0;  respond();  #1;
        chk("fl.c5.ce", 64'(bus.mem_ce_o), 64'd1);
        chk("fl.c5.addr", 64'(bus.mem_addr_o), 64'h20);  tick();
        respond();  #1;
        m_if_data = mem_fn(32'h20);
        chk("fl.c6.ifdata", 64'(if_data_o), 64'(m_if_data));
        chk("fl.c6.stall", 64'(if_stallreq_o), 64'd0);
        if_ce_i = 1'b0;  tick();
        repeat (2) begin respond(); tick(); end

        // Request held across its done cycle is issued exactly once.
        resp_waits = 1;  rises = 0;  prev_ce = bus.mem_ce_o;
        d_ce_i = 1'b1;  d_we_i = 1'b0;  d_sel_i = 4'hF;  d_addr_i = 32'h180;
        for (int t = 0; t < 9; t++) begin
            if (t == 4) d_ce_i = 1'b0;
            respond();
            #1;
            if (bus.mem_ce_o && !prev_ce) rises++;
            prev_ce = bus.mem_ce_o;
            if (t == 3) begin
                chk("nore.stall", 64'(d_stallreq_o), 64'd0);
                chk("nore.rdata", 64'(d_rdata_o), 64'(mem_fn(32'h180)));
            end
            tick();
        end
        chk("nore.rises", 64'(rises), 64'd1);

        // Reset in the second data-bus cycle; a late ack must be ignored.
        resp_waits = 5;
        d_ce_i = 1'b1;  d_we_i = 1'b1;  d_sel_i = 4'h5;  d_addr_i = 32'h300;  d_wdata_i = 32'h77;
        respond();  #1;  tick();
        respond();  #1;  chk("rstm.c1.ce", 64'(bus.mem_ce_o), 64'd1);  tick();
        rst = 1'b1;  respond();  #1;  tick();
        rst = 1'b0;  d_ce_i = 1'b0;  resp_en = 1'b0;
        bus.mem_ack_i = 1'b1;  bus.mem_data_i = 32'hFFFF_FFFF;  #1;
        chk("rstm.ce",     64'(bus.mem_ce_o),   64'd0);
        chk("rstm.we",     64'(bus.mem_we_o),   64'd0);
        chk("rstm.sel",    64'(bus.mem_sel_o),  64'd0);
        chk("rstm.addr",   64'(bus.mem_addr_o), 64'd0);
        chk("rstm.wdata",  64'(bus.mem_data_o), 64'd0);
        chk("rstm.ifdata", 64'(if_data_o),      64'd0);
        chk("rstm.drdata", 64'(d_rdata_o),      64'd0);
        tick();
        #1;
        chk("rstm.late.ce",     64'(bus.mem_ce_o), 64'd0);
        chk("rstm.late.drdata", 64'(d_rdata_o),    64'd0);
        bus.mem_ack_i = 1'b0;  resp_en = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
